mccoy_fetch: RTL and testbench

- Program store and sequencer that produces the 3-bit opcode consumed by the McCoy control decoder.
- Takes back the decoder's bez/ja controls and the x8 zero flag to form the next PC.
- Program loaded serially (MSB first) from the chip inputs, then executed one instruction per clock until a halt opcode.
- Sits between the TinyTapeout IO pins and the decoder/datapath.

---
 rtl/mccoy_fetch.sv | 166 ++++++++++++++++
 tb/tb_mccoy_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mccoy_fetch.sv
// rtl/mccoy_fetch.sv - program store and sequencer feeding the McCoy control decoder
//
// Holds a DEPTH x IW program loaded serially (MSB first) and steps through it
// one instruction per clock, returning the 3-bit opcode to the decoder and
// forming the next PC from the decoder's bez/ja controls and the x8 zero flag.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   load_en            level, selects serial program-load mode
//   prog_valid         qualifies prog_bit for one cycle
//   prog_bit           serial instruction bit, MSB first
//   run                starts execution from IDLE
//   bez, ja, x8_zero   decoder branch/jump controls and datapath zero flag
//   opcode, imm        fetched instruction fields (3'b111 / 0 outside RUN)
//   pc                 current program counter
//   running, halted    state indicators for RUN and HALT
//   loaded             complete words written since last LOAD entry, saturating
module mccoy_fetch #(
    parameter int AW    = 4,
    parameter int DEPTH = 16,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic          prog_valid,
    input  logic          prog_bit,
    input  logic          run,
    input  logic          bez,
    input  logic          ja,
    input  logic          x8_zero,
    output logic [2:0]    opcode,
    output logic [4:0]    imm,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted,
    output logic [AW:0]   loaded
);

    localparam int             BCW        = $clog2(IW);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(IW - 1);
    localparam logic [AW:0]    LOADED_MAX = (AW + 1)'(DEPTH);
    localparam logic [2:0]     OP_HALT    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [IW-1:0]   shift_q, shift_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [AW:0]     loaded_q, loaded_d;

    // Program store: no reset so a loaded program survives a reset.
    logic [IW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [IW-1:0]   mem_wdata;
    logic [IW-1:0]   fetch_word;
    logic            in_run;

    assign in_run     = (state_q == S_RUN);
    assign fetch_word = mem[pc_q];
    // The eighth bit goes straight into memory on the same edge it is shifted in.
    assign mem_wdata  = {shift_q[IW-2:0], prog_bit};

    assign opcode  = in_run ? fetch_word[IW-1:IW-3] : OP_HALT;
    assign imm     = in_run ? fetch_word[4:0] : 5'd0;
    assign pc      = pc_q;
    assign running = in_run;
    assign halted  = (state_q == S_HALT);
    assign loaded  = loaded_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wr_addr_d = wr_addr_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        loaded_d  = loaded_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    state_d   = S_LOAD;
                    wr_addr_d = '0;
                    bit_cnt_d = '0;
                    loaded_d  = '0;
                end else if (run) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_LOAD: begin
                // Leaving LOAD drops any partial word; entry clears bit_cnt again.
                if (!load_en) begin
                    state_d = S_IDLE;
                end else if (prog_valid) begin
                    shift_d = mem_wdata;
                    if (bit_cnt_q == BIT_LAST) begin
                        mem_we    = !reset;
                        bit_cnt_d = '0;
                        wr_addr_d = wr_addr_q + AW'(1);
                        if (loaded_q != LOADED_MAX) begin
                            loaded_d = loaded_q + (AW + 1)'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_RUN: begin
                if (load_en) begin
                    state_d   = S_LOAD;
                    pc_d      = '0;
                    wr_addr_d = '0;
                    bit_cnt_d = '0;
                    loaded_d  = '0;
                end else if (fetch_word[IW-1:IW-3] == OP_HALT) begin
                    state_d = S_HALT;
                end else if (ja || (bez && x8_zero)) begin
                    // Only the low AW target bits address the store.
                    pc_d = fetch_word[AW-1:0];
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            S_HALT: begin
                if (load_en && !run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            wr_addr_q <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            loaded_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wr_addr_q <= wr_addr_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            loaded_q  <= loaded_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mccoy_fetch.sv
// tb/tb_mccoy_fetch.sv - scoreboard bench for mccoy_fetch against a behavioural program model
module tb_mccoy_fetch;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, load_en, prog_valid, prog_bit, run, bez, ja, x8_zero;
    logic [2:0]    opcode;
    logic [4:0]    imm;
    logic [AW-1:0] pc;
    logic          running, halted;
    logic [AW:0]   loaded;

    mccoy_fetch #(.AW(AW), .DEPTH(DEPTH), .IW(8)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .prog_valid(prog_valid),
        .prog_bit(prog_bit), .run(run), .bez(bez), .ja(ja), .x8_zero(x8_zero),
        .opcode(opcode), .imm(imm), .pc(pc), .running(running), .halted(halted),
        .loaded(loaded)
    );

    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [4:0] im;
        logic [3:0] pcv;
        logic       rn;
        logic       hl;
        logic [4:0] ld;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    bit    started = 0;
    bit    done = 0;
    string cur_tag = "init";

    // Behavioural model: program as an array of bytes, serial load as an
    // accumulating integer, execution as an integer pc.
    int m_mode = M_IDLE;
    int m_pc = 0, m_wa = 0, m_acc = 0, m_nb = 0, m_ld = 0;
    int m_mem [DEPTH];

    function automatic int m_word();
        return m_mem[m_pc];
    endfunction

    function automatic int m_opcode();
        return (m_mode == M_RUN) ? (m_word() / 32) : 7;
    endfunction

    task automatic model_update(input bit r, le, pv, pb, rn, bz, j, x8);
        if (r) begin
            m_mode = M_IDLE; m_pc = 0; m_wa = 0; m_acc = 0; m_nb = 0; m_ld = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (le) begin
                    m_mode = M_LOAD; m_wa = 0; m_nb = 0; m_ld = 0;
                end else if (rn) begin
                    m_mode = M_RUN; m_pc = 0;
                end
            end
            M_LOAD: begin
                if (!le) begin
                    m_mode = M_IDLE;
                end else if (pv) begin
                    m_acc = (m_acc * 2 + int'(pb)) % 256;
                    m_nb  = m_nb + 1;
                    if (m_nb == 8) begin
                        m_mem[m_wa] = m_acc;
                        m_wa = (m_wa + 1) % DEPTH;
                        m_nb = 0;
                        if (m_ld < DEPTH) m_ld = m_ld + 1;
                    end
                end
            end
            M_RUN: begin
                if (le) begin
                    m_mode = M_LOAD; m_pc = 0; m_wa = 0; m_nb = 0; m_ld = 0;
                end else if (m_word() / 32 == 7) begin
                    m_mode = M_HALT;
                end else if (j || (bz && x8)) begin
                    m_pc = m_word() % DEPTH;
                end else begin
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
            default: begin
                if (le && !rn) m_mode = M_IDLE;
            end
        endcase
    endtask

    // One clock of stimulus: drive at the falling edge, record what the DUT
    // must be showing during this cycle, then advance the model past the
    // coming rising edge.
    task automatic step(input bit r, le, pv, pb, rn, bz, j, x8);
        exp_t e;
        @(negedge clk);
        reset = r; load_en = le; prog_valid = pv; prog_bit = pb;
        run = rn; bez = bz; ja = j; x8_zero = x8;
        e.tag = cur_tag;
        e.op  = 3'(m_opcode());
        e.im  = (m_mode == M_RUN) ? 5'(m_word() % 32) : 5'd0;
        e.pcv = 4'(m_pc);
        e.rn  = (m_mode == M_RUN);
        e.hl  = (m_mode == M_HALT);
        e.ld  = 5'(m_ld);
        sb.push_back(e);
        model_update(r, le, pv, pb, rn, bz, j, x8);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enter_load();
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(0, 1, 1, b[i], 0, 0, 0, 0);
    endtask

    task automatic load_prog(input logic [7:0] p [DEPTH]);
        enter_load();
        for (int i = 0; i < DEPTH; i++) load_byte(p[i]);
        idle_step();
    endtask

    task automatic start_run();
        step(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Stand-in decoder: opcode 000 asserts bez, opcode 010 asserts ja.
    task automatic exec(input int n, input bit x8);
        for (int i = 0; i < n; i++) begin
            int op;
            op = m_opcode();
            step(0, 0, 0, 0, 0, op == 0, op == 2, x8);
        end
    endtask

    logic [7:0] prog [DEPTH];

    initial begin
        foreach (m_mem[i]) m_mem[i] = 0;
        reset = 1; load_en = 0; prog_valid = 0; prog_bit = 0;
        run = 0; bez = 0; ja = 0; x8_zero = 0;
        repeat (2) @(negedge clk);
        started = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle_step();
        #1;
        check("reset_opcode", int'(opcode), 7);
        check("reset_running", int'(running), 0);

        // Fill the whole store so every later fetch has a known word.
        cur_tag = "fill";
        foreach (prog[i]) prog[i] = 8'h21;
        load_prog(prog);
        #1;
        check("fill_loaded", int'(loaded), 16);

        cur_tag = "basic";
        enter_load();
        load_byte(8'h21);
        load_byte(8'hE0);
        idle_step();
        #1;
        check("basic_loaded", int'(loaded), 2);
        start_run();
        exec(1, 0);
        #1;
        check("basic_op0", int'(opcode), 1);
        check("basic_imm0", int'(imm), 1);
        exec(2, 0);
        #1;
        check("basic_halted", int'(halted), 1);
        check("basic_halt_pc", int'(pc), 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle_step();

        cur_tag = "bez";
        foreach (prog[i]) prog[i] = 8'h21;
        prog[0] = 8'h05; prog[5] = 8'hE0; prog[1] = 8'hE0;
        load_prog(prog);
        start_run();
        exec(2, 1);
        #1;
        check("bez_taken_pc", int'(pc), 5);
        exec(2, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        start_run();
        exec(2, 0);
        #1;
        check("bez_not_taken_pc", int'(pc), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        cur_tag = "ja";
        foreach (prog[i]) prog[i] = 8'h21;
        prog[3] = 8'h4A; prog[10] = 8'hE0; prog[11] = 8'h5A;
        load_prog(prog);
        start_run();
        exec(5, 0);
        #1;
        check("ja_target_pc", int'(pc), 10);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        foreach (prog[i]) prog[i] = 8'h21;
        prog[3] = 8'h5A; prog[10] = 8'hE0;
        load_prog(prog);
        start_run();
        exec(5, 0);
        #1;
        check("ja_wide_target_pc", int'(pc), 10);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        cur_tag = "wrap";
        enter_load();
        for (int i = 0; i < 16; i++) load_byte(8'h21);
        load_byte(8'h35);
        idle_step();
        #1;
        check("wrap_loaded_sat", int'(loaded), 16);
        start_run();
        exec(20, 0);
        #1;
        check("wrap_pc", int'(pc), 3);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        cur_tag = "partial";
        enter_load();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 0, 0, 0);
        idle_step();
        start_run();
        exec(1, 0);
        #1;
        check("partial_mem0_op", int'(opcode), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle_step();
        enter_load();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 0, 0);
        idle_step();
        enter_load();
        load_byte(8'hE0);
        idle_step();
        start_run();
        exec(1, 0);
        #1;
        check("partial_reentry_op", int'(opcode), 7);
        exec(1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        cur_tag = "reset_run";
        foreach (prog[i]) prog[i] = 8'h21;
        load_prog(prog);
        start_run();
        exec(8, 0);
        #1;
        check("rst_pre_pc", int'(pc), 7);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle_step();
        #1;
        check("rst_post_pc", int'(pc), 0);
        check("rst_post_opcode", int'(opcode), 7);
        start_run();
        exec(3, 0);

        cur_tag = "random";
        for (int seg = 0; seg < 60; seg++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 3) begin
                enter_load();
                repeat ($urandom_range(4, 40))
                    step(0, 1, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 0);
                step(0, 0, 0, 0, 1'($urandom % 2), 0, 0, 0);
            end else if (k < 9) begin
                start_run();
                repeat ($urandom_range(3, 30))
                    step(0, 1'($urandom % 25 == 0), 0, 0, 1'($urandom % 2),
                         1'($urandom % 2), 1'($urandom % 3 == 0), 1'($urandom % 2));
                step(0, 1'($urandom % 2), 0, 0, 1'($urandom % 2), 0, 0, 0);
                idle_step();
            end else begin
                step(1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0, 0);
            end
        end
        idle_step();
        done = 1;
    end

    // Monitor: pops one expected snapshot per cycle and compares it against
    // the outputs the DUT presents, sampled mid-cycle.
    initial begin
        int cyc;
        exp_t e;
        cyc = 0;
        wait (started);
        while (!(done && sb.size() == 0)) begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc > 60000) begin
                total++;
                bad++;
                $display("FAIL timeout: got %0d cycles expected completion", cyc);
                break;
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (opcode !== e.op || imm !== e.im || pc !== e.pcv ||
                    running !== e.rn || halted !== e.hl || loaded !== e.ld) begin
                    bad++;
                    $display("FAIL %s: got op=%0d imm=%0d pc=%0d run=%0d halt=%0d ld=%0d expected op=%0d imm=%0d pc=%0d run=%0d halt=%0d ld=%0d",
                             e.tag, opcode, imm, pc, running, halted, loaded,
                             e.op, e.im, e.pcv, e.rn, e.hl, e.ld);
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
